// File: rtl/conv_ctrl_strided.sv
// Strided convolution controller: loads layer parameters, weights and ifmap windows
// from DRAM, then issues ofmap psum reads and pipelined write-backs per window.
module conv_ctrl_strided #(
  parameter int ADDR_WIDTH = 18,
  parameter int KNL_W      = 5,
  parameter int KNL_H      = 5,
  parameter int MAX_KNLS   = 16,
  parameter int KID_W      = $clog2(MAX_KNLS),
  parameter int CH_W       = 5,
  parameter int XY_W       = 5,
  parameter int DIM_W      = 6,
  parameter int PIPE_LAT   = 4,
  parameter int PARAM_BASE = 0,
  parameter int WTS_BASE   = 64,
  parameter int IFMAP_BASE = 65536,
  parameter int OFMAP_BASE = 131072
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  enable,
  input  logic [DIM_W-1:0]      param_in,
  input  logic                  mem_rdy,
  output logic [ADDR_WIDTH-1:0] addr_in,
  output logic [ADDR_WIDTH-1:0] addr_out,
  output logic                  dram_en_rd,
  output logic                  dram_en_wr,
  output logic                  en_ld_knl,
  output logic                  en_ld_ifmap,
  output logic                  disable_acc,
  output logic [CH_W-1:0]       num_knls,
  output logic [CH_W-1:0]       cnt_ofmap_chnl,
  output logic                  done,
  output logic                  err_param,
  output logic                  busy
);

  localparam int WTS_N = KNL_W * KNL_H;
  localparam int WTS_W = $clog2(WTS_N);
  localparam int CC_W  = $clog2(MAX_KNLS + PIPE_LAT + 1);
  localparam int DW1   = DIM_W + 1;

  typedef enum logic [2:0] {
    IDLE, LD_PARAM, CHECK, LD_KNLS, LD_IFMAP_FULL, LD_IFMAP_PART, CONV, DONE
  } state_t;

  state_t            state;
  logic [2:0]        p_idx, pidx_d;
  logic              pv;
  logic [DIM_W-1:0]  knls_r, depth_r, height_r, width_r, stride_r;
  logic [CH_W-1:0]   chnl;
  logic [KID_W-1:0]  knl_id;
  logic [WTS_W-1:0]  wts;
  logic [XY_W-1:0]   dx, dy, base_x, base_y, out_x, out_y;
  logic [CC_W-1:0]   cc, wk;

  logic [XY_W-1:0]   fx, fy, px;
  logic              param_ok, conv_last, conv_rd, conv_wr;
  logic              step_x, step_y, next_chnl, last_knl, part_last_dx;

  assign fy = base_y + dy;
  assign fx = base_x + dx;
  // Partial loads only fetch the new right-hand columns of the slid window.
  assign px = base_x + XY_W'(KNL_W) - XY_W'(stride_r) + dx;
  assign wk = cc - CC_W'(PIPE_LAT);

  // Stride is checked straight from param_in: its word lands in the CHECK cycle.
  assign param_ok = (knls_r != '0) && (DW1'(knls_r) <= DW1'(MAX_KNLS)) &&
                    (depth_r != '0) &&
                    (DW1'(height_r) >= DW1'(KNL_H)) &&
                    (DW1'(width_r) >= DW1'(KNL_W)) &&
                    (param_in != '0) && (DW1'(param_in) <= DW1'(KNL_W));

  assign conv_last    = (DW1'(cc) == DW1'(knls_r) + DW1'(PIPE_LAT - 1));
  assign conv_rd      = (DW1'(cc) < DW1'(knls_r));
  assign conv_wr      = (DW1'(cc) >= DW1'(PIPE_LAT));
  assign step_x       = (DW1'(base_x) + DW1'(stride_r) + DW1'(KNL_W)) <= DW1'(width_r);
  assign step_y       = (DW1'(base_y) + DW1'(stride_r) + DW1'(KNL_H)) <= DW1'(height_r);
  assign next_chnl    = (DW1'(chnl) + DW1'(1)) < DW1'(depth_r);
  assign last_knl     = (knl_id == KID_W'(knls_r - DIM_W'(1)));
  assign part_last_dx = (dx == XY_W'(stride_r - DIM_W'(1)));

  assign busy     = (state != IDLE);
  assign num_knls = knls_r[CH_W-1:0];

  always_comb begin
    dram_en_rd     = 1'b0;
    dram_en_wr     = 1'b0;
    addr_in        = '0;
    addr_out       = '0;
    cnt_ofmap_chnl = '0;
    disable_acc    = 1'b0;
    case (state)
      LD_PARAM: begin
        dram_en_rd = 1'b1;
        addr_in    = ADDR_WIDTH'(PARAM_BASE) + ADDR_WIDTH'(p_idx);
      end
      LD_KNLS: begin
        dram_en_rd = 1'b1;
        addr_in    = ADDR_WIDTH'(WTS_BASE) +
                     ADDR_WIDTH'({knl_id, chnl[CH_W-2:0], wts});
      end
      LD_IFMAP_FULL: begin
        dram_en_rd = 1'b1;
        addr_in    = ADDR_WIDTH'(IFMAP_BASE) + ADDR_WIDTH'({chnl, fy, fx});
      end
      LD_IFMAP_PART: begin
        dram_en_rd = 1'b1;
        addr_in    = ADDR_WIDTH'(IFMAP_BASE) + ADDR_WIDTH'({chnl, fy, px});
      end
      CONV: begin
        disable_acc = (chnl == '0);
        if (conv_rd) begin
          dram_en_rd = 1'b1;
          addr_in    = ADDR_WIDTH'(OFMAP_BASE) +
                       ADDR_WIDTH'({cc[KID_W-1:0], out_y, out_x});
        end
        // Write-back of kernel k trails its psum read by PIPE_LAT accepted cycles.
        if (conv_wr) begin
          dram_en_wr     = 1'b1;
          addr_out       = ADDR_WIDTH'(OFMAP_BASE) +
                           ADDR_WIDTH'({wk[KID_W-1:0], out_y, out_x});
          cnt_ofmap_chnl = CH_W'(wk);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state       <= IDLE;
      p_idx       <= '0;
      pidx_d      <= '0;
      pv          <= 1'b0;
      knls_r      <= '0;
      depth_r     <= '0;
      height_r    <= '0;
      width_r     <= '0;
      stride_r    <= '0;
      chnl        <= '0;
      knl_id      <= '0;
      wts         <= '0;
      dx          <= '0;
      dy          <= '0;
      base_x      <= '0;
      base_y      <= '0;
      out_x       <= '0;
      out_y       <= '0;
      cc          <= '0;
      en_ld_knl   <= 1'b0;
      en_ld_ifmap <= 1'b0;
      done        <= 1'b0;
      err_param   <= 1'b0;
    end else begin
      done        <= 1'b0;
      en_ld_knl   <= (state == LD_KNLS) && mem_rdy;
      en_ld_ifmap <= ((state == LD_IFMAP_FULL) || (state == LD_IFMAP_PART)) && mem_rdy;
      pv          <= (state == LD_PARAM) && mem_rdy;
      pidx_d      <= p_idx;
      if (pv) begin
        case (pidx_d)
          3'd0:    knls_r   <= param_in;
          3'd1:    depth_r  <= param_in;
          3'd2:    height_r <= param_in;
          3'd3:    width_r  <= param_in;
          default: stride_r <= param_in;
        endcase
      end

      case (state)
        IDLE: begin
          if (enable) begin
            err_param <= 1'b0;
            p_idx     <= '0;
            state     <= LD_PARAM;
          end
        end
        LD_PARAM: begin
          if (mem_rdy) begin
            if (p_idx == 3'd4) begin
              p_idx <= '0;
              state <= CHECK;
            end else begin
              p_idx <= p_idx + 3'd1;
            end
          end
        end
        CHECK: begin
          if (!param_ok) begin
            err_param <= 1'b1;
            done      <= 1'b1;
            state     <= DONE;
          end else begin
            chnl   <= '0;
            knl_id <= '0;
            wts    <= '0;
            dx     <= '0;
            dy     <= '0;
            base_x <= '0;
            base_y <= '0;
            out_x  <= '0;
            out_y  <= '0;
            cc     <= '0;
            state  <= LD_KNLS;
          end
        end
        LD_KNLS: begin
          if (mem_rdy) begin
            if (wts == WTS_W'(WTS_N - 1)) begin
              wts <= '0;
              if (last_knl) begin
                knl_id <= '0;
                state  <= LD_IFMAP_FULL;
              end else begin
                knl_id <= knl_id + KID_W'(1);
              end
            end else begin
              wts <= wts + WTS_W'(1);
            end
          end
        end
        LD_IFMAP_FULL: begin
          if (mem_rdy) begin
            if (dy == XY_W'(KNL_H - 1)) begin
              dy <= '0;
              if (dx == XY_W'(KNL_W - 1)) begin
                dx    <= '0;
                cc    <= '0;
                state <= CONV;
              end else begin
                dx <= dx + XY_W'(1);
              end
            end else begin
              dy <= dy + XY_W'(1);
            end
          end
        end
        LD_IFMAP_PART: begin
          if (mem_rdy) begin
            if (dy == XY_W'(KNL_H - 1)) begin
              dy <= '0;
              if (part_last_dx) begin
                dx    <= '0;
                cc    <= '0;
                state <= CONV;
              end else begin
                dx <= dx + XY_W'(1);
              end
            end else begin
              dy <= dy + XY_W'(1);
            end
          end
        end
        CONV: begin
          if (mem_rdy) begin
            if (conv_last) begin
              cc <= '0;
              if (step_x) begin
                base_x <= base_x + XY_W'(stride_r);
                out_x  <= out_x + XY_W'(1);
                state  <= LD_IFMAP_PART;
              end else if (step_y) begin
                base_x <= '0;
                out_x  <= '0;
                base_y <= base_y + XY_W'(stride_r);
                out_y  <= out_y + XY_W'(1);
                state  <= LD_IFMAP_FULL;
              end else if (next_chnl) begin
                chnl   <= chnl + CH_W'(1);
                base_x <= '0;
                base_y <= '0;
                out_x  <= '0;
                out_y  <= '0;
                state  <= LD_KNLS;
              end else begin
                done  <= 1'b1;
                state <= DONE;
              end
            end else begin
              cc <= cc + CC_W'(1);
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_ctrl_strided.sv
// Scoreboard bench for conv_ctrl_strided: expected DRAM accesses are queued per test,
// a negedge monitor pops and compares every accepted read and write.
module tb_conv_ctrl_strided;
  localparam int AW    = 18;
  localparam int CH_W  = 5;
  localparam int DIM_W = 6;

  logic clk = 1'b0;
  logic arst = 1'b1;
  logic enable = 1'b0;
  logic mem_rdy = 1'b1;
  logic [DIM_W-1:0] param_in = '0;
  logic [AW-1:0] addr_in, addr_out;
  logic dram_en_rd, dram_en_wr, en_ld_knl, en_ld_ifmap, disable_acc;
  logic [CH_W-1:0] num_knls, cnt_ofmap_chnl;
  logic done, err_param, busy;

  conv_ctrl_strided #(
    .ADDR_WIDTH(AW), .KNL_W(5), .KNL_H(5), .MAX_KNLS(16), .CH_W(CH_W), .XY_W(5),
    .DIM_W(DIM_W), .PIPE_LAT(4), .PARAM_BASE(0), .WTS_BASE(64),
    .IFMAP_BASE(65536), .OFMAP_BASE(131072)
  ) dut (
    .clk(clk), .arst(arst), .enable(enable), .param_in(param_in), .mem_rdy(mem_rdy),
    .addr_in(addr_in), .addr_out(addr_out), .dram_en_rd(dram_en_rd),
    .dram_en_wr(dram_en_wr), .en_ld_knl(en_ld_knl), .en_ld_ifmap(en_ld_ifmap),
    .disable_acc(disable_acc), .num_knls(num_knls), .cnt_ofmap_chnl(cnt_ofmap_chnl),
    .done(done), .err_param(err_param), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned addr;
    int unsigned k;
    bit          dis;
  } wr_t;

  int unsigned rq[$];
  wr_t         wq[$];
  int unsigned aq[$];
  int unsigned prm[5];
  int tests = 0;
  int fails = 0;
  int unsigned rd_cnt = 0, wr_cnt = 0, done_cnt = 0, if_cnt = 0, of_cnt = 0;
  int unsigned acc = 0, last_wr = 0;
  bit exp_knl = 1'b0, exp_if = 1'b0, prev_done = 1'b0;
  logic [DIM_W-1:0] pend = '0;

  task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: actual %0d required %0d", nm, act, exp);
    end
  endtask

  // Monitor and DRAM model: param words return one cycle after their read is accepted.
  always @(negedge clk) begin
    bit nk, ni;
    wr_t w;
    int unsigned e;
    nk = 1'b0;
    ni = 1'b0;
    param_in = pend;
    pend = '0;
    if (arst) begin
      prev_done = 1'b0;
    end else begin
      chk("en_ld_knl", en_ld_knl, exp_knl);
      chk("en_ld_ifmap", en_ld_ifmap, exp_if);
      if (!dram_en_rd) chk("addr_in_idle", addr_in, 0);
      if (!dram_en_wr) chk("addr_out_idle", addr_out, 0);
      if (dram_en_rd && mem_rdy) begin
        rd_cnt++;
        if (rq.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_read: actual addr %0d required no read", addr_in);
        end else begin
          e = rq.pop_front();
          chk("rd_addr", addr_in, e);
          if (e < 5) pend = DIM_W'(prm[e]);
          else if (e < 65536) nk = 1'b1;
          else if (e < 131072) begin ni = 1'b1; if_cnt++; end
          else begin of_cnt++; aq.push_back(acc); end
        end
      end else if (dram_en_rd && rq.size() > 0) begin
        chk("rd_hold", addr_in, rq[0]);
      end
      if (dram_en_wr && mem_rdy) begin
        wr_cnt++;
        last_wr = addr_out;
        if (wq.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_write: actual addr %0d required no write", addr_out);
        end else begin
          w = wq.pop_front();
          chk("wr_addr", addr_out, w.addr);
          chk("wr_chnl", cnt_ofmap_chnl, w.k);
          chk("disable_acc", disable_acc, w.dis);
          if (aq.size() > 0) chk("wr_latency", acc - aq.pop_front(), 4);
        end
      end else if (dram_en_wr && wq.size() > 0) begin
        chk("wr_hold", addr_out, wq[0].addr);
      end
      if (done) begin
        done_cnt++;
        chk("done_one_cycle", prev_done, 0);
      end
      prev_done = done;
      if (mem_rdy) acc++;
    end
    exp_knl = nk;
    exp_if  = ni;
  end

  task automatic gen_expected(input int unsigned kn, d, h, w, s, input bit bad);
    int unsigned by, bx, oy, ox;
    for (int unsigned i = 0; i < 5; i++) rq.push_back(i);
    if (bad) return;
    for (int unsigned c = 0; c < d; c++) begin
      for (int unsigned k = 0; k < kn; k++)
        for (int unsigned t = 0; t < 25; t++) rq.push_back(64 + k*512 + c*32 + t);
      by = 0; oy = 0;
      while (by + 5 <= h) begin
        bx = 0; ox = 0;
        while (bx + 5 <= w) begin
          if (ox == 0) begin
            for (int unsigned x = 0; x < 5; x++)
              for (int unsigned y = 0; y < 5; y++)
                rq.push_back(65536 + c*1024 + (by+y)*32 + bx + x);
          end else begin
            for (int unsigned x = 0; x < s; x++)
              for (int unsigned y = 0; y < 5; y++)
                rq.push_back(65536 + c*1024 + (by+y)*32 + bx + 5 - s + x);
          end
          for (int unsigned k = 0; k < kn; k++) begin
            rq.push_back(131072 + k*1024 + oy*32 + ox);
            wq.push_back('{addr: 131072 + k*1024 + oy*32 + ox, k: k, dis: (c == 0)});
          end
          bx += s; ox++;
        end
        by += s; oy++;
      end
    end
  endtask

  task automatic start_test(input string nm, input int unsigned kn, d, h, w, s, input bit bad);
    prm = '{kn, d, h, w, s};
    rd_cnt = 0; wr_cnt = 0; done_cnt = 0; if_cnt = 0; of_cnt = 0;
    gen_expected(kn, d, h, w, s, bad);
    @(posedge clk); #2 enable = 1'b1;
    @(posedge clk); #2 enable = 1'b0;
    chk({nm, "_err_cleared"}, err_param, 0);
    chk({nm, "_busy"}, busy, 1);
  endtask

  task automatic finish_test(input string nm, input int unsigned ex_rd, ex_wr, input bit ex_err);
    int unsigned n;
    n = 0;
    while (done_cnt == 0 && n < 20000) begin @(posedge clk); n++; end
    repeat (3) @(posedge clk);
    #2;
    chk({nm, "_done_pulses"}, done_cnt, 1);
    chk({nm, "_reads"}, rd_cnt, ex_rd);
    chk({nm, "_writes"}, wr_cnt, ex_wr);
    chk({nm, "_err_param"}, err_param, ex_err);
    chk({nm, "_rd_left"}, rq.size(), 0);
    chk({nm, "_wr_left"}, wq.size(), 0);
    chk({nm, "_idle"}, busy, 0);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_addr_in"}, addr_in, 0);
    chk({nm, "_addr_out"}, addr_out, 0);
    chk({nm, "_rd"}, dram_en_rd, 0);
    chk({nm, "_wr"}, dram_en_wr, 0);
    chk({nm, "_ld_knl"}, en_ld_knl, 0);
    chk({nm, "_ld_ifmap"}, en_ld_ifmap, 0);
    chk({nm, "_dis_acc"}, disable_acc, 0);
    chk({nm, "_num_knls"}, num_knls, 0);
    chk({nm, "_chnl"}, cnt_ofmap_chnl, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_err"}, err_param, 0);
    chk({nm, "_busy"}, busy, 0);
  endtask

  task automatic wait_cnt(input bit use_of, input int unsigned target);
    int unsigned n;
    n = 0;
    while (((use_of ? of_cnt : if_cnt) < target) && n < 5000) begin @(posedge clk); n++; end
    chk(use_of ? "reach_ofmap_reads" : "reach_ifmap_reads",
        (use_of ? of_cnt : if_cnt) >= target, 1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2 chk_zero("reset");
    arst = 1'b0;
    repeat (4) @(posedge clk);
    #2 chk("no_start_without_enable", busy, 0);
    chk("no_access_without_enable", rd_cnt + wr_cnt, 0);

    // 1 kernel, 1 channel, 5x5, stride 1: 5 + 25 + 25 + 1 reads, one write
    start_test("basic", 1, 1, 5, 5, 1, 0);
    finish_test("basic", 56, 1, 0);
    chk("basic_wr_addr", last_wr, 131072);
    chk("basic_num_knls", num_knls, 1);

    // 2 kernels, 7x7, stride 2: four windows, last write 131072+{1,1,1}
    start_test("stride2", 2, 1, 7, 7, 2, 0);
    finish_test("stride2", 133, 8, 0);
    chk("stride2_last_wr", last_wr, 132129);

    // two input channels: disable_acc only in channel 0, weights reloaded
    start_test("depth2", 1, 2, 5, 5, 1, 0);
    finish_test("depth2", 107, 2, 0);

    // bad parameters
    start_test("bad_width", 1, 1, 5, 4, 1, 1);
    finish_test("bad_width", 5, 0, 1);
    start_test("bad_stride", 1, 1, 5, 5, 6, 1);
    finish_test("bad_stride", 5, 0, 1);

    // stalls mid ifmap load and mid CONV
    start_test("stall", 2, 1, 5, 5, 1, 0);
    wait_cnt(1'b0, 10);
    #2 mem_rdy = 1'b0;
    repeat (3) @(posedge clk);
    #2 mem_rdy = 1'b1;
    wait_cnt(1'b1, 1);
    #2 mem_rdy = 1'b0;
    repeat (3) @(posedge clk);
    #2 mem_rdy = 1'b1;
    finish_test("stall", 82, 2, 0);

    // reset in the middle of CONV, then a clean restart
    start_test("rst_conv", 2, 1, 7, 7, 2, 0);
    wait_cnt(1'b1, 1);
    #2 arst = 1'b1;
    #1 chk_zero("rst_mid");
    rq.delete(); wq.delete(); aq.delete();
    rd_cnt = 0; wr_cnt = 0;
    repeat (2) @(posedge clk);
    #2 arst = 1'b0;
    repeat (8) @(posedge clk);
    #2 chk("rst_conv_idle", busy, 0);
    chk("rst_conv_no_access", rd_cnt + wr_cnt, 0);
    start_test("restart", 1, 1, 5, 5, 1, 0);
    finish_test("restart", 56, 1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
